// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the set-associative cache controller.
//   state_t : controller state encoding (IDLE, WB, FILL, FINAL)
//   clog2   : elaboration-time ceiling log2, used to size the word offset
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    FILL  = 2'd2,
    FINAL = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_ctrl_assoc_fill_tracker.sv
// fill_tracker: MEM_LAT-stage shift register that follows refill reads
// through the fixed-latency memory pipeline. Each cycle a (valid, offset)
// pair enters at stage 0; the last stage says which word returns now.
//   clk         : clock
//   rst         : synchronous active-low reset (clears the valid bits)
//   push_valid  : a memory read was accepted this cycle
//   push_offset : word offset of that read
//   out_valid   : read data for out_offset is valid this cycle
//   out_offset  : word offset of the returning data
module fill_tracker #(
  parameter int DEPTH = 2,
  parameter int OFF_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [OFF_W-1:0] push_offset,
  output logic             out_valid,
  output logic [OFF_W-1:0] out_offset
);

  logic [DEPTH-1:0] vld;
  logic [OFF_W-1:0] off [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's old value and the shift happens in one step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld <= '0;
    end else begin
      vld[0] <= push_valid;
      for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
    end
  end

  // NOTE: the offset stages are storage qualified by vld, so they carry no
  // reset; only the valid bits must be cleared.
  always_ff @(posedge clk) begin
    off[0] <= push_offset;
    for (int i = 1; i < DEPTH; i++) off[i] <= off[i-1];
  end

  assign out_valid  = vld[DEPTH-1];
  assign out_offset = off[DEPTH-1];

endmodule

// File: rtl/cache_ctrl_assoc.sv
// cache_ctrl_assoc: control FSM for a 1- or 2-way cache in front of a
// pipelined fixed-latency memory. Hits complete combinationally in IDLE;
// misses write back a dirty victim word by word (WB), refill the line with
// overlapping reads (FILL), then merge the request (FINAL).
//   clk, rst              : clock, synchronous active-low reset
//   rd, wr                : load / store request, held until done
//   hit, valid, dirty     : per-way status of the indexed line
//   mem_stall             : memory cannot accept an access this cycle
//   cache_en, comp, write, valid_in, cache_offset, fill_sel : way-array control
//   mem_rd, mem_wr, mem_offset, mem_victim_tag              : memory control
//   done, stall, cache_hit, err                             : requester status
module cache_ctrl_assoc
  import cache_ctrl_pkg::*;
#(
  parameter  int WAYS           = 2,
  parameter  int WORDS_PER_LINE = 4,
  parameter  int MEM_LAT        = 2,
  localparam int OFF_W          = clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd,
  input  logic             wr,
  input  logic [WAYS-1:0]  hit,
  input  logic [WAYS-1:0]  valid,
  input  logic [WAYS-1:0]  dirty,
  input  logic             mem_stall,
  output logic [WAYS-1:0]  cache_en,
  output logic             comp,
  output logic             write,
  output logic             valid_in,
  output logic [OFF_W-1:0] cache_offset,
  output logic             fill_sel,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [OFF_W-1:0] mem_offset,
  output logic             mem_victim_tag,
  output logic             done,
  output logic             stall,
  output logic             cache_hit,
  output logic             err
);

  // Issue counter needs one extra bit to represent "all words issued".
  localparam int               CNT_W      = OFF_W + 1;
  localparam logic [CNT_W-1:0] LINE_WORDS = CNT_W'(WORDS_PER_LINE);
  localparam logic [OFF_W-1:0] LAST_OFF   = OFF_W'(WORDS_PER_LINE - 1);

  function automatic logic [WAYS-1:0] way_onehot(input logic idx);
    return WAYS'(1) << idx;
  endfunction

  state_t           state;
  logic [OFF_W-1:0] wb_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             victim;
  logic             victim_by_ptr;
  logic             ptr;

  logic             req;
  logic [WAYS-1:0]  hit_vec;
  logic             hit_any;
  logic             hit_way;
  logic             any_invalid;
  logic             inv_way;
  logic             sel_way;
  logic             victim_dirty;
  logic             rd_issue;
  logic             rd_accept;
  logic             ret_valid;
  logic [OFF_W-1:0] ret_offset;

  assign req = rd ^ wr;

  // Hit way and victim choice are priority encoders favouring the lowest
  // index; the loop runs high-to-low so the lowest match wins.
  always_comb begin
    hit_vec     = hit & valid;
    hit_any     = |hit_vec;
    any_invalid = |(~valid);
    hit_way     = 1'b0;
    inv_way     = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = 1'(i);
      if (!valid[i])  inv_way = 1'(i);
    end
    sel_way      = any_invalid ? inv_way : ptr;
    victim_dirty = |(way_onehot(sel_way) & valid & dirty);
  end

  assign rd_issue  = (state == FILL) && (rd_cnt < LINE_WORDS);
  assign rd_accept = rd_issue && !mem_stall;

  fill_tracker #(
    .DEPTH (MEM_LAT),
    .OFF_W (OFF_W)
  ) u_fill_tracker (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (rd_accept),
    .push_offset (rd_cnt[OFF_W-1:0]),
    .out_valid   (ret_valid),
    .out_offset  (ret_offset)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      wb_cnt        <= '0;
      rd_cnt        <= '0;
      victim        <= 1'b0;
      victim_by_ptr <= 1'b0;
      ptr           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wb_cnt <= '0;
          rd_cnt <= '0;
          if (req && !hit_any) begin
            victim        <= sel_way;
            victim_by_ptr <= !any_invalid;
            state         <= victim_dirty ? WB : FILL;
          end
        end
        WB: begin
          if (!mem_stall) begin
            wb_cnt <= wb_cnt + 1'b1;
            if (wb_cnt == LAST_OFF) state <= FILL;
          end
        end
        FILL: begin
          if (rd_accept) rd_cnt <= rd_cnt + 1'b1;
          // Reads return in issue order, so the last offset closes the fill.
          if (ret_valid && (ret_offset == LAST_OFF)) state <= FINAL;
        end
        FINAL: begin
          if (victim_by_ptr && (WAYS == 2)) ptr <= ~ptr;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state and live inputs: an IDLE hit must
  // complete in the cycle the request appears.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    cache_en       = '0;
    comp           = 1'b0;
    write          = 1'b0;
    valid_in       = 1'b0;
    cache_offset   = '0;
    fill_sel       = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_offset     = '0;
    mem_victim_tag = 1'b0;
    done           = 1'b0;
    stall          = 1'b0;
    cache_hit      = 1'b0;
    err            = 1'b0;
    case (state)
      IDLE: begin
        if (rd && wr) begin
          err  = 1'b1;
          done = 1'b1;
        end else if (req) begin
          comp     = 1'b1;
          write    = wr;
          cache_en = '1;
          if (hit_any) begin
            cache_en  = way_onehot(hit_way);
            done      = 1'b1;
            cache_hit = 1'b1;
          end
        end
      end
      WB: begin
        stall          = 1'b1;
        cache_en       = way_onehot(victim);
        cache_offset   = wb_cnt;
        mem_wr         = 1'b1;
        mem_offset     = wb_cnt;
        mem_victim_tag = 1'b1;
      end
      FILL: begin
        stall = 1'b1;
        if (rd_issue) begin
          mem_rd     = 1'b1;
          mem_offset = rd_cnt[OFF_W-1:0];
        end
        if (ret_valid) begin
          write        = 1'b1;
          valid_in     = 1'b1;
          fill_sel     = 1'b1;
          cache_en     = way_onehot(victim);
          cache_offset = ret_offset;
        end
      end
      FINAL: begin
        stall    = 1'b1;
        comp     = 1'b1;
        write    = wr;
        cache_en = way_onehot(victim);
        done     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cache_ctrl_assoc.md
Name: cache_ctrl_assoc

Overview:
Parametrised successor to the direct-mapped cache controller FSM. It supports 1 or 2 ways, configurable line length, and a pipelined fixed-latency banked memory. On a miss it writes back a dirty victim word by word, then refills the line with overlapping reads. It sits between the processor memory stage and the cache way arrays and main-memory model, and drives only control signals; the datapath muxes live outside.

Parameters:
WAYS, 2, number of ways; 1 or 2 supported.
WORDS_PER_LINE, 4, words per cache line; power of 2, at least 2.
MEM_LAT, 2, cycles from an accepted memory read to its data being valid; at least 1.
OFF_W (localparam), clog2(WORDS_PER_LINE), word-offset width.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous active-low reset
rd  in  1  load request; held by the requester until done
wr  in  1  store request; held by the requester until done
hit  in  WAYS  per-way tag match from the way arrays
valid  in  WAYS  per-way valid bit of the indexed line
dirty  in  WAYS  per-way dirty bit of the indexed line
mem_stall  in  1  memory cannot accept an access this cycle
cache_en  out  WAYS  one-hot way enable
comp  out  1  cache compare mode
write  out  1  cache write
valid_in  out  1  valid bit to store on a fill write
cache_offset  out  OFF_W  word offset into the cache line
fill_sel  out  1  cache data_in taken from memory data (1) or from the processor (0)
mem_rd  out  1  memory read
mem_wr  out  1  memory write
mem_offset  out  OFF_W  word offset presented to memory
mem_victim_tag  out  1  memory address tag taken from the victim line (1) or from the request (0)
done  out  1  request complete this cycle
stall  out  1  controller busy
cache_hit  out  1  request satisfied without any memory traffic
err  out  1  rd and wr asserted together

Behaviour:
- rst=0 sampled at an edge: state=IDLE, counters=0, fill pipeline cleared, victim pointer=way0. Reset mid-operation abandons the operation; no further memory traffic is issued. With no request pending, all outputs are 0.
- IDLE, rd^wr: compare is combinational in the same cycle. comp=1, write=wr, cache_en=all ones.
- IDLE, hit: a hit is hit[i]&valid[i]. done=1, cache_hit=1, cache_en=onehot(i), stay in IDLE. Zero extra latency.
- IDLE, miss: latch the victim way.
  - Victim selection: the lowest-index invalid way if one exists; otherwise the victim pointer.
  - Next state is WB if the victim is valid&dirty, else FILL.
- IDLE, rd&wr: err=1 and done=1 for one cycle; no array access.
- WB: comp=0, write=0, cache_en=victim, cache_offset=k, mem_wr=1, mem_offset=k, mem_victim_tag=1. k increments only when mem_stall=0. After word WORDS_PER_LINE-1 is accepted, go to FILL.
- FILL, issue side: mem_rd=1, mem_offset=j, mem_victim_tag=0. j increments when mem_stall=0 and j<WORDS_PER_LINE.
- FILL, return side: each accepted read pushes (1, j) into a MEM_LAT-deep shift register. The shift register advances every cycle regardless of mem_stall.
- FILL, install: when the register output is valid, assert comp=0, write=1, valid_in=1, fill_sel=1, cache_en=victim, cache_offset=returned offset. Issue and install may occur in the same cycle.
- FILL exit: go to FINAL in the cycle after the last word is installed.
- FINAL: comp=1, write=wr, cache_en=victim, fill_sel=0. Store data is merged here. done=1, cache_hit=0. Toggle the victim pointer if the victim was chosen by the pointer (WAYS=2), then go to IDLE.
- stall=1 in WB, FILL and FINAL; stall=0 in IDLE.
- Request inputs are ignored outside IDLE.

Decomposition:
- Package cache_ctrl_pkg: state encoding localparams (IDLE, WB, FILL, FINAL) and a clog2 function.
- Sub-module fill_tracker: MEM_LAT-stage valid+offset shift register with synchronous active-low reset; used for the FILL return side.

Test Plan:
Defaults for all scenarios: WAYS=2, WORDS_PER_LINE=4, MEM_LAT=2. Request presented at cycle 0.
1. rd=1, hit=10, valid=10 -> cycle 0: done=1, cache_hit=1, cache_en=10, comp=1, write=0, stall=0.
2. rd=1, valid=00 -> victim way0.
   - mem_rd at cycles 1-4 with offsets 0-3.
   - Installs at cycles 3-6 with valid_in=1, fill_sel=1, cache_en=01.
   - Cycle 7: done=1, cache_hit=0.
3. wr=1, valid=11, dirty=11, pointer=way0 ->
   - mem_wr with mem_victim_tag=1 at cycles 1-4, offsets 0-3.
   - mem_rd at cycles 5-8; installs at cycles 7-10.
   - Cycle 11: comp=1, write=1, done=1; pointer becomes way1.
4. Scenario 2 with mem_stall=1 at cycle 2 -> offset 1 issued at cycle 3; installs at cycles 3,5,6,7; done at cycle 8.
5. Two consecutive clean misses with valid=11 -> first fills way0, second fills way1; reset then returns the pointer to way0.
6. rst=0 at cycle 3 of scenario 2 -> cycle 4: IDLE, all outputs 0, no mem_rd. Separately, rd=wr=1 -> err=1, done=1 in the same cycle.
